// File: rtl/alphamission_snd_pkg.sv
// alphamission_snd_pkg: shared types and constants for the sound command transmitter
package alphamission_snd_pkg;
  localparam int SND_CMD_W = 8;
  localparam int ST_TX_ACTIVE = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_TMO = 3;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_SET, WAIT_CLR} snd_tx_st_t;
endpackage

// File: rtl/alphamission_snd_cmd_fifo.sv
// snd_cmd_fifo: DEPTH x 8 command queue; a push while full is taken only if a pop frees a slot
module snd_cmd_fifo
  import alphamission_snd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SND_CMD_W-1:0] din,
  output logic [SND_CMD_W-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count
);
  logic [SND_CMD_W-1:0] mem_q [DEPTH];
  logic [SND_CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alphamission_snd_cmd_tx.sv
// alphamission_snd_cmd_tx: queues main-CPU sound commands and hands them to the sound board
// one at a time, paced by the board's busy flag.
module alphamission_snd_cmd_tx
  import alphamission_snd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETUP_CYC = 4,
  parameter int STROBE_CYC = 8,
  parameter int TMO_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_wr,
  input  logic [SND_CMD_W-1:0] cpu_din,
  input  logic                 clr_err,
  output logic [SND_CMD_W-1:0] snd_data,
  output logic                 snd_mcode,
  input  logic                 snd_busy,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 ovf,
  output logic                 tmo,
  output logic [7:0]           status
);
  snd_tx_st_t st_q, st_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [SND_CMD_W-1:0] data_q, data_d, head;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic busy_m_q, busy_s_q, mcode_q, mcode_d, ovf_q, ovf_d, tmo_q, tmo_d, pop, tmo_ev;
  snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(cpu_wr), .pop(pop), .din(cpu_din), .dout(head),
    .full(), .empty(), .count(fifo_cnt)
  );
  assign fifo_empty = fifo_cnt == '0;
  assign fifo_full = fifo_cnt == ($clog2(DEPTH)+1)'(DEPTH);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    data_d = data_q;
    pop = 1'b0;
    tmo_ev = 1'b0;
    case (st_q)
      IDLE: if (!fifo_empty && !busy_s_q) begin
        pop = 1'b1;
        data_d = head;
        cnt_d = '0;
        st_d = SETUP;
      end
      SETUP: if (cnt_q == TMO_W'(SETUP_CYC-1)) begin
        cnt_d = '0;
        st_d = STROBE;
      end
      STROBE: if (cnt_q == TMO_W'(STROBE_CYC-1)) begin
        cnt_d = '0;
        st_d = WAIT_SET;
      end
      WAIT_SET: if (busy_s_q) begin
        cnt_d = '0;
        st_d = WAIT_CLR;
      end else if (&cnt_q) begin
        tmo_ev = 1'b1;
        st_d = IDLE;
      end
      WAIT_CLR: if (!busy_s_q) st_d = IDLE;
        else if (&cnt_q) begin
          tmo_ev = 1'b1;
          st_d = IDLE;
        end
      default: st_d = IDLE;
    endcase
    // strobe is registered from the next state so the pin never glitches
    mcode_d = st_d == STROBE;
    ovf_d = (cpu_wr && fifo_full && !pop) || (ovf_q && !clr_err);
    tmo_d = tmo_ev || (tmo_q && !clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      mcode_q <= 1'b0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      busy_m_q <= 1'b0;
      busy_s_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      mcode_q <= mcode_d;
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
      busy_m_q <= snd_busy;
      busy_s_q <= busy_m_q;
    end
  assign snd_data = data_q;
  assign snd_mcode = mcode_q;
  assign ovf = ovf_q;
  assign tmo = tmo_q;
  always_comb begin
    status = '0;
    status[ST_TX_ACTIVE] = st_q != IDLE;
    status[ST_FULL] = fifo_full;
    status[ST_OVF] = ovf_q;
    status[ST_TMO] = tmo_q;
  end
endmodule

// File: tb/tb_alphamission_snd_cmd_tx.sv
// tb_alphamission_snd_cmd_tx: scoreboard bench; a monitor checks every strobe against queued bytes
module tb_alphamission_snd_cmd_tx;
  localparam int SETUP_CYC = 4;
  localparam int STROBE_CYC = 8;
  localparam int TMO_W = 8;
  logic clk = 0, rst = 1, cpu_wr = 0, clr_err = 0;
  logic [7:0] cpu_din = 0;
  logic busy_mdl = 0, busy_frc = 0, model_en = 1;
  logic snd_busy, snd_mcode, fifo_empty, fifo_full, ovf, tmo;
  logic [7:0] snd_data, status;
  int vectors = 0, errors = 0, cyc = 0, wr_cyc = 0, hi_cnt = 0;
  bit lat_chk = 0;
  logic prev = 0;
  logic [7:0] exp_q[$];

  assign snd_busy = model_en ? busy_mdl : busy_frc;

  alphamission_snd_cmd_tx #(.DEPTH(4), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .clr_err(clr_err),
    .snd_data(snd_data), .snd_mcode(snd_mcode), .snd_busy(snd_busy),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .ovf(ovf), .tmo(tmo), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev = 0;
      hi_cnt = 0;
    end else begin
      if (snd_mcode && !prev) begin
        chk("busy_low_at_strobe", int'(snd_busy), 0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_strobe: got data %0h expected no strobe", snd_data);
        end else chk("snd_data_order", int'(snd_data), int'(exp_q.pop_front()));
        if (lat_chk) begin
          chk("write_to_strobe_latency", cyc - wr_cyc, SETUP_CYC + 1);
          lat_chk = 0;
        end
        hi_cnt = 1;
      end else if (snd_mcode) hi_cnt++;
      else if (prev) chk("strobe_width", hi_cnt, STROBE_CYC);
      prev = snd_mcode;
    end
  end

  // sound board: busy rises 3 cycles after the strobe, sound CPU clears it 50 cycles later
  always begin
    @(posedge snd_mcode);
    repeat (3) @(posedge clk);
    #1 busy_mdl = 1;
    repeat (50) @(posedge clk);
    #1 busy_mdl = 0;
  end

  task automatic wr(input logic [7:0] b, input bit expect_push);
    @(negedge clk);
    cpu_wr = 1;
    cpu_din = b;
    if (expect_push) exp_q.push_back(b);
    @(posedge clk);
    #1 cpu_wr = 0;
    wr_cyc = cyc;
  endtask

  task automatic clr();
    @(negedge clk);
    clr_err = 1;
    @(posedge clk);
    #1 clr_err = 0;
  endtask

  task automatic hold_busy(input logic v);
    @(negedge clk);
    model_en = !v;
    busy_frc = v;
    if (v) repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || status[0] || !fifo_empty) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, int'(n >= 3000), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_snd_data", int'(snd_data), 0);
    chk("rst_snd_mcode", int'(snd_mcode), 0);
    chk("rst_fifo_empty", int'(fifo_empty), 1);
    chk("rst_fifo_full", int'(fifo_full), 0);
    chk("rst_status", int'(status), 0);
    rst = 0;
    repeat (2) @(negedge clk);

    lat_chk = 1;
    wr(8'h5A, 1);
    drain("t1");
    chk("t1_latency_seen", int'(lat_chk), 0);
    chk("t1_data_held", int'(snd_data), 8'h5A);
    chk("t1_status_idle", int'(status), 0);

    hold_busy(1);
    for (int i = 1; i <= 4; i++) wr(8'(i), 1);
    chk("t2_full", int'(fifo_full), 1);
    chk("t2_status", int'(status), 8'h02);
    hold_busy(0);
    drain("t2");
    chk("t2_empty", int'(fifo_empty), 1);
    chk("t2_last_data", int'(snd_data), 8'h04);

    hold_busy(1);
    for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i), 1);
    wr(8'h15, 0);
    chk("t3_ovf_set", int'(ovf), 1);
    chk("t3_status", int'(status), 8'h06);
    clr();
    chk("t3_ovf_clr", int'(ovf), 0);
    chk("t3_still_full", int'(fifo_full), 1);
    hold_busy(0);
    drain("t3");
    chk("t3_last_data", int'(snd_data), 8'h14);

    @(negedge clk);
    model_en = 0;
    busy_frc = 0;
    wr(8'hAA, 1);
    wr(8'hBB, 1);
    drain("t4");
    chk("t4_tmo", int'(tmo), 1);
    chk("t4_status", int'(status), 8'h08);
    chk("t4_last_data", int'(snd_data), 8'hBB);
    clr();
    chk("t4_tmo_clr", int'(tmo), 0);

    hold_busy(1);
    wr(8'h77, 1);
    repeat (30) @(negedge clk);
    chk("t5_byte_waits", int'(fifo_empty), 0);
    chk("t5_not_active", int'(status[0]), 0);
    hold_busy(0);
    drain("t5");
    chk("t5_data", int'(snd_data), 8'h77);
    chk("t5_no_tmo", int'(tmo), 0);

    wr(8'h3C, 1);
    wr(8'h3D, 1);
    begin
      int n = 0;
      while (!snd_mcode && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t6_strobe_timeout", int'(n >= 100), 0);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_mcode_async_drop", int'(snd_mcode), 0);
    chk("t6_fifo_empty", int'(fifo_empty), 1);
    chk("t6_status", int'(status), 0);
    chk("t6_data_cleared", int'(snd_data), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 0;
    wr(8'h99, 1);
    drain("t6");
    chk("t6_data_after", int'(snd_data), 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
